// File: rtl/seg_scan_if.sv
// seg_scan_if: multiplexed seven-segment bus plus the decoded per-digit results
interface seg_scan_if #(
  parameter int DIGITS = 8
);
  logic [7:0]          seg;
  logic [DIGITS-1:0]   an;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   dp_out;
  logic [DIGITS-1:0]   valid;
  logic                update;
  logic                err;
  logic                err_kind;
  modport master (output seg, an, input hex_out, dp_out, valid, update, err, err_kind);
  modport slave  (input seg, an, output hex_out, dp_out, valid, update, err, err_kind);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces an active-low 7-seg scan bus and decodes each digit to hex.
// Define SEG_SCAN_DP_EN to capture the decimal point per digit.
module seg_scan_decoder #(
  parameter int DIGITS        = 8,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seg_scan_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int W  = 8 + DIGITS;
`ifdef SEG_SCAN_DP_EN
  localparam logic [W-1:0] MASK = '1;
`else
  localparam logic [W-1:0] MASK = {8'hFE, {DIGITS{1'b1}}};
`endif
  typedef enum logic {SETTLE, HELD} state_t;
  state_t              state, state_n;
  logic [7:0]          s_seg;
  logic [DIGITS-1:0]   s_an;
  logic [W-1:0]        prev;
  logic [CW-1:0]       cnt, cnt_n;
  logic                changed, full, eval, dp_val;
  logic [6:0]          p;
  logic [4:0]          dec;
  logic [4*DIGITS-1:0] hex_q, hex_n;
  logic [DIGITS-1:0]   dp_q, dp_n, valid_q, valid_n;
  logic                upd_q, upd_n, err_q, err_n, kind_q, kind_n;

  // returns {legal, value} for an active-high abcdefg pattern
  function automatic logic [4:0] decode(input logic [6:0] v);
    case (v)
      7'b1111110: decode = 5'h10;
      7'b0110000: decode = 5'h11;
      7'b1101101: decode = 5'h12;
      7'b1111001: decode = 5'h13;
      7'b0110011: decode = 5'h14;
      7'b1011011: decode = 5'h15;
      7'b1011111: decode = 5'h16;
      7'b1110000: decode = 5'h17;
      7'b1111111: decode = 5'h18;
      7'b1110011: decode = 5'h19;
      7'b1110111: decode = 5'h1A;
      7'b0011111: decode = 5'h1B;
      7'b0001101: decode = 5'h1C;
      7'b0111101: decode = 5'h1D;
      7'b1101111: decode = 5'h1E;
      7'b1000111: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  assign p       = ~s_seg[7:1];
  assign dec     = decode(p);
  assign changed = |(({s_seg, s_an} ^ prev) & MASK);
  assign full    = cnt == CW'(STABLE_CYCLES);
  assign eval    = !changed && state == SETTLE && full;
`ifdef SEG_SCAN_DP_EN
  assign dp_val  = ~s_seg[0];
`else
  assign dp_val  = 1'b0;
`endif

  always_comb begin
    state_n = changed ? SETTLE : eval ? HELD : state;
    cnt_n   = changed ? CW'(1) : full ? cnt : cnt + CW'(1);
  end

  always_comb begin
    hex_n   = hex_q;
    valid_n = valid_q;
    dp_n    = dp_q;
    upd_n   = 1'b0;
    err_n   = 1'b0;
    kind_n  = 1'b0;
    if (eval && !(&s_an)) begin
      if (!$onehot(~s_an)) begin
        err_n  = 1'b1;
        kind_n = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          if (!s_an[d]) begin
            if (p == 7'd0) begin
              valid_n[d] = 1'b0;
              dp_n[d]    = dp_val;
            end else if (dec[4]) begin
              hex_n[4*d +: 4] = dec[3:0];
              valid_n[d]      = 1'b1;
              dp_n[d]         = dp_val;
              upd_n           = 1'b1;
            end else begin
              valid_n[d] = 1'b0;
              err_n      = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SETTLE;
      cnt     <= '0;
      s_seg   <= 8'hFF;
      s_an    <= '1;
      prev    <= '1;
      hex_q   <= '0;
      dp_q    <= '0;
      valid_q <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      kind_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      s_seg   <= bus.seg;
      s_an    <= bus.an;
      prev    <= {s_seg, s_an};
      hex_q   <= hex_n;
      dp_q    <= dp_n;
      valid_q <= valid_n;
      upd_q   <= upd_n;
      err_q   <= err_n;
      kind_q  <= kind_n;
    end
  end

  assign bus.hex_out  = hex_q;
  assign bus.dp_out   = dp_q;
  assign bus.valid    = valid_q;
  assign bus.update   = upd_q;
  assign bus.err      = err_q;
  assign bus.err_kind = kind_q;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed and randomized scan-bus stimulus checked against a run-length model
module tb_seg_scan_decoder;
  localparam int DIGITS = 8;
  localparam int SC     = 4;
`ifdef SEG_SCAN_DP_EN
  localparam bit DPEN = 1'b1;
`else
  localparam bit DPEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  seg_scan_if #(.DIGITS(DIGITS)) bus();
  seg_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(SC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [6:0] tbl [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
                           7'b0001101, 7'b0111101, 7'b1101111, 7'b1000111};
  logic [31:0] m_hex;
  logic [7:0]  m_valid, m_dp, pend_seg, pend_an;
  logic        m_upd, m_err, m_kind;
  logic [15:0] run_val;
  int          run_len;
  bit          pend;

  function automatic logic [15:0] key(input logic [7:0] s, input logic [7:0] a);
    return {s[7:1], DPEN ? s[0] : 1'b0, a};
  endfunction

  function automatic logic [50:0] obs();
    return {bus.hex_out, bus.valid, bus.dp_out, bus.update, bus.err, bus.err & bus.err_kind};
  endfunction

  function automatic logic [50:0] exp_v();
    return {m_hex, m_valid, m_dp, m_upd, m_err, m_err & m_kind};
  endfunction

  task automatic model_reset();
    m_hex = '0; m_valid = '0; m_dp = '0;
    m_upd = 0; m_err = 0; m_kind = 0;
    pend = 0; run_len = 0; run_val = '0;
  endtask

  task automatic model_eval(input logic [7:0] s, input logic [7:0] a);
    int lows = 0;
    int idx  = 0;
    int v    = -1;
    logic [6:0] pp = ~s[7:1];
    if (a == 8'hFF) return;
    for (int i = 0; i < DIGITS; i++) if (!a[i]) begin lows++; idx = i; end
    if (lows > 1) begin m_err = 1; m_kind = 1; return; end
    for (int i = 0; i < 16; i++) if (tbl[i] == pp) v = i;
    if (pp == 7'd0) begin
      m_valid[idx] = 0; m_dp[idx] = DPEN & ~s[0];
    end else if (v >= 0) begin
      m_hex[4*idx +: 4] = v[3:0]; m_valid[idx] = 1; m_dp[idx] = DPEN & ~s[0]; m_upd = 1;
    end else begin
      m_err = 1; m_kind = 0; m_valid[idx] = 0;
    end
  endtask

  // A run of SC+1 identical samples commits on the following edge.
  task automatic step(input logic [7:0] s, input logic [7:0] a);
    bus.seg = s;
    bus.an  = a;
    @(posedge clk);
    m_upd = 0; m_err = 0; m_kind = 0;
    if (pend) begin model_eval(pend_seg, pend_an); pend = 0; end
    if (run_len > 0 && key(s, a) == run_val) run_len++;
    else begin run_val = key(s, a); run_len = 1; end
    if (run_len == SC + 1) begin pend = 1; pend_seg = s; pend_an = a; end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; bus.seg = 8'hFF; bus.an = 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (obs() !== '0) begin mismatched++; $display("FAIL reset: got %h want 0", obs()); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_legal();
    int ups = 0;
    for (int k = 0; k < 8; k++) begin
      step(8'h25, 8'hFE);
      ups += int'(bus.update);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL legal step %0d: got %h want %h", k, obs(), exp_v()); end
      if (k == 5) begin
        compared++;
        if (bus.update !== 1'b1) begin mismatched++; $display("FAIL legal update_edge5: got %b want 1", bus.update); end
      end
    end
    compared++;
    if (bus.hex_out[3:0] !== 4'h2 || bus.valid !== 8'h01 || ups != 1) begin
      mismatched++; $display("FAIL legal final: hex %h valid %h ups %0d want 2 01 1", bus.hex_out[3:0], bus.valid, ups);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 2; k++) begin
      step(8'h25, 8'hFD);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL glitch pre %0d: got %h want %h", k, obs(), exp_v()); end
    end
    for (int k = 0; k < 7; k++) begin
      step(8'h9F, 8'hFD);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL glitch step %0d: got %h want %h", k, obs(), exp_v()); end
      if (k == 4 || k == 5) begin
        compared++;
        if (bus.valid[1] !== (k == 5)) begin mismatched++; $display("FAIL glitch valid1 k%0d: got %b want %b", k, bus.valid[1], k == 5); end
      end
    end
    compared++;
    if (bus.hex_out[7:0] !== 8'h12) begin mismatched++; $display("FAIL glitch hex: got %h want 12", bus.hex_out[7:0]); end
  endtask

  task automatic test_illegal();
    int errs = 0;
    for (int k = 0; k < 6; k++) step(8'h9F, 8'hFB);
    for (int k = 0; k < 7; k++) begin
      step(8'h7F, 8'hFB);
      errs += int'(bus.err);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL illegal step %0d: got %h want %h", k, obs(), exp_v()); end
    end
    compared++;
    if (bus.hex_out[11:8] !== 4'h1 || bus.valid[2] !== 1'b0 || errs != 1) begin
      mismatched++; $display("FAIL illegal final: hex %h valid2 %b errs %0d want 1 0 1", bus.hex_out[11:8], bus.valid[2], errs);
    end
  endtask

  task automatic test_multi();
    int errs = 0;
    int pulses = 0;
    for (int k = 0; k < 7; k++) begin
      step(8'h9F, 8'hFC);
      errs += int'(bus.err & bus.err_kind);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL multi step %0d: got %h want %h", k, obs(), exp_v()); end
    end
    for (int k = 0; k < 7; k++) begin
      step(8'h9F, 8'hFF);
      pulses += int'(bus.err | bus.update);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL idle step %0d: got %h want %h", k, obs(), exp_v()); end
    end
    compared++;
    if (errs != 1 || pulses != 0 || bus.valid !== 8'h03 || bus.hex_out[11:0] !== 12'h112) begin
      mismatched++; $display("FAIL multi final: errs %0d pulses %0d valid %h hex %h want 1 0 03 112", errs, pulses, bus.valid, bus.hex_out[11:0]);
    end
  endtask

  task automatic test_reset_mid();
    int early = 0;
    for (int k = 0; k < 3; k++) step(8'h25, 8'hEF);
    #2 rst = 1;
    #1;
    model_reset();
    compared++;
    if (obs() !== '0) begin mismatched++; $display("FAIL reset_mid async: got %h want 0", obs()); end
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 8; k++) begin
      step(8'h25, 8'hEF);
      if (k < 5) early += int'(bus.update);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL reset_mid step %0d: got %h want %h", k, obs(), exp_v()); end
    end
    compared++;
    if (early != 0 || bus.hex_out[19:16] !== 4'h2) begin
      mismatched++; $display("FAIL reset_mid final: early %0d hex %h want 0 2", early, bus.hex_out[19:16]);
    end
  endtask

  task automatic test_dp();
    for (int k = 0; k < 7; k++) begin
      step(8'h24, 8'h7F);
      compared++;
      if (obs() !== exp_v()) begin mismatched++; $display("FAIL dp step %0d: got %h want %h", k, obs(), exp_v()); end
    end
    compared++;
    if (bus.hex_out[31:28] !== 4'h2 || bus.dp_out[7] !== DPEN) begin
      mismatched++; $display("FAIL dp final: hex %h dp %b want 2 %b", bus.hex_out[31:28], bus.dp_out[7], DPEN);
    end
  endtask

  task automatic test_random();
    logic [7:0] s, a;
    int r;
    for (int h = 0; h < 80; h++) begin
      r = $urandom_range(0, 9);
      if (r < 6) s = {~tbl[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      else if (r < 7) s = {7'h7F, 1'($urandom_range(0, 1))};
      else s = 8'($urandom);
      r = $urandom_range(0, 9);
      a = 8'hFF;
      if (r < 6) a[$urandom_range(0, 7)] = 1'b0;
      else if (r > 6) a = 8'($urandom);
      for (int k = $urandom_range(1, 8); k > 0; k--) begin
        step(s, a);
        compared++;
        if (obs() !== exp_v()) begin mismatched++; $display("FAIL random h%0d seg %h an %h: got %h want %h", h, s, a, obs(), exp_v()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_legal();
    test_glitch();
    test_illegal();
    test_multi();
    test_reset_mid();
    test_dp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
